// File: rtl/muldiv_iter_unit.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle.
// MULDIV_SIGNED_EN adds signed operation selected by op[2].
module muldiv_iter_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic [DATA_WIDTH-1:0]    src_a,
   input  logic [DATA_WIDTH-1:0]    src_b,
   input  logic [ADDRESS_WIDTH-1:0] dest,
   output logic                     busy,
   output logic                     res_wrt_en,
   output logic [ADDRESS_WIDTH-1:0] res_dest,
   output logic [DATA_WIDTH-1:0]    res_data
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [1:0]               op_q, op_d;
   logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
   logic [W-1:0]             b_q, b_d;
   logic [2*W-1:0]           prod_q, prod_d;
   logic [W:0]               rem_q, rem_d;
   logic [W-1:0]             quo_q, quo_d;
   logic                     busy_q, busy_d;
   logic                     wrt_en_q, wrt_en_d;
   logic [ADDRESS_WIDTH-1:0] res_dest_q, res_dest_d;
   logic [W-1:0]             res_data_q, res_data_d;

   logic                     accept;
   logic [W-1:0]             a_mag, b_mag;
   logic [W:0]               mul_sum;
   logic [W:0]               div_sh;
   logic [W+1:0]             div_diff;
   logic [2*W-1:0]           prod_res;
   logic [W-1:0]             quo_res, rem_res;
   logic                     unused_rem_msb;

`ifdef MULDIV_SIGNED_EN
   logic sa, sb;
   logic qneg_q, qneg_d, rneg_q, rneg_d;

   assign sa       = op[2] & src_a[W-1];
   assign sb       = op[2] & src_b[W-1];
   assign a_mag    = sa ? -src_a : src_a;
   assign b_mag    = sb ? -src_b : src_b;
   assign prod_res = qneg_q ? -prod_q : prod_q;
   assign quo_res  = qneg_q ? -quo_q : quo_q;
   assign rem_res  = rneg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
`else
   logic unused_op2;

   assign unused_op2 = op[2];
   assign a_mag      = src_a;
   assign b_mag      = src_b;
   assign prod_res   = prod_q;
   assign quo_res    = quo_q;
   assign rem_res    = rem_q[W-1:0];
`endif

   // The write-back cycle is already IDLE but busy is still high, so
   // gating on busy_q keeps start ignored there as well.
   assign accept         = start & (state_q == IDLE) & ~busy_q;
   assign unused_rem_msb = rem_q[W];

   assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + {1'b0, b_q};
   assign div_sh   = {rem_q[W-1:0], quo_q[W-1]};
   assign div_diff = {1'b0, div_sh} - {2'b00, b_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      dest_d     = dest_q;
      b_d        = b_q;
      prod_d     = prod_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      busy_d     = accept | (state_q != IDLE);
      wrt_en_d   = 1'b0;
      res_dest_d = res_dest_q;
      res_data_d = res_data_q;
`ifdef MULDIV_SIGNED_EN
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = CALC;
               cnt_d   = '0;
               op_d    = op[1:0];
               dest_d  = dest;
               b_d     = b_mag;
               prod_d  = {{W{1'b0}}, a_mag};
               rem_d   = '0;
               quo_d   = a_mag;
`ifdef MULDIV_SIGNED_EN
               qneg_d  = (sa ^ sb) & (|src_b);
               rneg_d  = sa;
`endif
            end
         end
         CALC: begin
            cnt_d = cnt_q + CW'(1);
            if (!op_q[1]) begin
               prod_d = prod_q[0] ? {mul_sum, prod_q[W-1:1]}
                                  : {1'b0, prod_q[2*W-1:1]};
            end else if (!div_diff[W+1]) begin
               rem_d = div_diff[W:0];
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = div_sh;
               quo_d = {quo_q[W-2:0], 1'b0};
            end
            if (cnt_q == CW'(W-1)) state_d = DONE;
         end
         DONE: begin
            state_d    = IDLE;
            wrt_en_d   = 1'b1;
            res_dest_d = dest_q;
            unique case (op_q)
               2'b00:   res_data_d = prod_res[W-1:0];
               2'b01:   res_data_d = prod_res[2*W-1:W];
               2'b10:   res_data_d = quo_res;
               default: res_data_d = rem_res;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         dest_q     <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         busy_q     <= 1'b0;
         wrt_en_q   <= 1'b0;
         res_dest_q <= '0;
         res_data_q <= '0;
`ifdef MULDIV_SIGNED_EN
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         dest_q     <= dest_d;
         b_q        <= b_d;
         prod_q     <= prod_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         busy_q     <= busy_d;
         wrt_en_q   <= wrt_en_d;
         res_dest_q <= res_dest_d;
         res_data_q <= res_data_d;
`ifdef MULDIV_SIGNED_EN
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign res_wrt_en = wrt_en_q;
   assign res_dest   = res_dest_q;
   assign res_data   = res_data_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed scoreboard bench for muldiv_iter_unit.
// Signed expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_iter_unit;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  dest;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  dest;
   logic        busy;
   logic        res_wrt_en;
   logic [4:0]  res_dest;
   logic [31:0] res_data;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   wrt_cnt = 0;

   muldiv_iter_unit #(
      .DATA_WIDTH(32),
      .ADDRESS_WIDTH(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .op(op),
      .src_a(src_a),
      .src_b(src_b),
      .dest(dest),
      .busy(busy),
      .res_wrt_en(res_wrt_en),
      .res_dest(res_dest),
      .res_data(res_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (res_wrt_en === 1'b1) wrt_cnt++;

   function automatic logic [31:0] model(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request; returns at the negedge after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] exp, input bit push);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      dest  = d;
      if (push) begin
         e.data = exp;
         e.dest = d;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      chk("busy_rise", {31'b0, busy}, 32'd1);
   endtask

   // Wait for the write-back strobe, k counts edges since acceptance.
   task automatic collect(input int k0, input bit poke);
      int   k;
      bit   got;
      exp_t e;
      k   = k0;
      got = 1'b0;
      while (k < 40 && !got) begin
         if (res_wrt_en === 1'b1) begin
            got = 1'b1;
         end else begin
            if (poke && k == 32) begin
               start = 1'b1;
               op    = 3'b000;
               src_a = 32'd11;
               src_b = 32'd13;
               dest  = 5'd31;
            end
            @(negedge clk);
            k++;
         end
      end
      chk("latency", k, 32'd33);
      e.data = 32'hDEAD_BEEF;
      e.dest = 5'd0;
      if (sb.size() > 0) e = sb.pop_front();
      chk("data", res_data, e.data);
      chk("dest", {27'b0, res_dest}, {27'b0, e.dest});
      @(negedge clk);
      start = 1'b0;
      chk("busy_fall", {31'b0, busy}, 32'd0);
      chk("wrt_fall", {31'b0, res_wrt_en}, 32'd0);
      chk("data_hold", res_data, e.data);
   endtask

   task automatic run(input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] d,
                      input logic [31:0] exp);
      issue(o, a, b, d, exp, 1'b1);
      collect(0, 1'b0);
   endtask

   initial begin
      int n0;
      logic [31:0] ra, rb;
      logic [1:0]  ro;

      rst   = 1'b1;
      start = 1'b1;
      op    = 3'b000;
      src_a = 32'd1;
      src_b = 32'd1;
      dest  = 5'd1;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_wrt", {31'b0, res_wrt_en}, 32'd0);
      chk("rst_dest", {27'b0, res_dest}, 32'd0);
      chk("rst_data", res_data, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      run(3'b000, 32'd7, 32'd6, 5'd5, 32'd42);
      run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
      run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001);
      run(3'b010, 32'd100, 32'd7, 5'd8, 32'd14);
      run(3'b011, 32'd100, 32'd7, 5'd9, 32'd2);
      run(3'b010, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);

      // start held across the last busy cycles must be dropped
      n0 = wrt_cnt;
      issue(3'b011, 32'd5, 32'd0, 5'd11, 32'd5, 1'b1);
      collect(0, 1'b1);
      repeat (40) @(negedge clk);
      chk("poke_ignored", wrt_cnt - n0, 32'd1);
      chk("poke_idle", {31'b0, busy}, 32'd0);

      n0 = wrt_cnt;
      issue(3'b010, 32'd100, 32'd7, 5'd12, 32'd14, 1'b1);
      repeat (9) @(negedge clk);
      start = 1'b1;
      op    = 3'b000;
      src_a = 32'd9;
      @(negedge clk);
      start = 1'b0;
      collect(10, 1'b0);
      repeat (5) @(negedge clk);
      chk("single_wb", wrt_cnt - n0, 32'd1);

      issue(3'b000, 32'd1234, 32'd5678, 5'd13, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_data", res_data, 32'd0);
      n0 = wrt_cnt;
      repeat (30) @(negedge clk);
      chk("abort_no_wb", wrt_cnt - n0, 32'd0);
      run(3'b000, 32'd3, 32'd3, 5'd14, 32'd9);

`ifdef MULDIV_SIGNED_EN
      run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFD);
      run(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFF);
      run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
      run(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
      run(3'b101, 32'hFFFF_FFFD, 32'd5, 5'd19, 32'hFFFF_FFFF);
      run(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd20, 32'hFFFF_FFFF);
      run(3'b111, 32'hFFFF_FFFB, 32'd0, 5'd21, 32'hFFFF_FFFB);
`else
      run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'h7FFF_FFFC);
      run(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'd1);
      run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0);
      run(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000);
      run(3'b101, 32'hFFFF_FFFD, 32'd5, 5'd19, 32'd4);
      run(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd20, 32'hFFFF_FFFF);
      run(3'b111, 32'hFFFF_FFFB, 32'd0, 5'd21, 32'hFFFF_FFFB);
`endif

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i == 2) rb = rb >> 20;
         ro = 2'(i % 4);
         run({1'b0, ro}, ra, rb, 5'(22 + i), model(ro, ra, rb));
      end

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
